latch_wr_ctrl: RTL and testbench
================================

# latch_wr_ctrl

Write-side sequencer for a bank of transparent D latches with per-latch enable and shared active-low clear. Accepts write and clear requests over a valid/ready handshake, then drives latch data, one-hot enable and clear with programmable setup, open and hold phases. This guarantees data is stable around every enable edge. It sits between the register/config logic and the latch bank it writes.

## Interface
- DW, 8, latch data width
- NLATCH, 4, number of latches in the bank (1..2**AW)
- AW, 2, address width
- SETUP_CYC, 1, cycles data is driven before enable rises (>=1)
- OPEN_CYC, 2, cycles enable (or clear) is held asserted (>=1)
- HOLD_CYC, 1, cycles data is held after enable falls (>=1)

- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  write request valid
- req_ready  out  1  high only in IDLE
- req_addr  in  AW  target latch index
- req_data  in  DW  data to write
- clr_valid  in  1  clear-all request; shares req_ready
- lat_d  out  DW  data to latch bank
- lat_en  out  NLATCH  one-hot latch enables
- lat_rstn  out  1  active-low clear to all latches
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE
- addr_err  out  1  pulses with done if the accepted address was >= NLATCH

## Operation
- States: IDLE, SETUP, OPEN, HOLD, CLEAR. One down-counter, width clog2(max(SETUP_CYC, OPEN_CYC, HOLD_CYC)+1).
- IDLE: req_ready=1. If clr_valid, accept the clear and go to CLEAR; clr_valid has priority over req_valid when both are high. Else, if req_valid, register addr/data, drive lat_d and go to SETUP.
- SETUP: lat_d=data, lat_en=0, for SETUP_CYC cycles, then OPEN.
- OPEN: lat_en[addr]=1, all other enable bits 0, for OPEN_CYC cycles, then HOLD. If addr>=NLATCH, lat_en stays 0 and the sequence otherwise runs unchanged.
- HOLD: lat_en=0, lat_d unchanged, for HOLD_CYC cycles, then IDLE.
- CLEAR: lat_rstn=0, lat_en=0, for OPEN_CYC cycles, then IDLE.
- lat_d changes only on acceptance in IDLE; it keeps the last written value otherwise. Clear does not change lat_d.
- Requests that arrive while busy are not accepted (ready=0). The requester must keep valid asserted.
- At most one bit of lat_en is ever high. lat_en and lat_rstn=0 are never active in the same cycle.

## Timing
- Reset values: req_ready=0 during reset and 1 from the first cycle after rstn deasserts. State=IDLE, lat_d=0, lat_en=0, lat_rstn=0 while rstn is sampled low (the bank is cleared during controller reset). lat_rstn=1 after reset. busy=0, done=0, addr_err=0.
- Reset mid-operation: sampled at the next edge. It aborts any sequence; no done pulse is produced.
- Write latency: accept at edge T. The SETUP cycles begin at T. lat_en is high in cycles T+SETUP_CYC .. T+SETUP_CYC+OPEN_CYC-1. done is high in cycle T+SETUP_CYC+OPEN_CYC+HOLD_CYC, which is the first IDLE cycle; req_ready is high in that same cycle.
- Clear latency: lat_rstn is low for OPEN_CYC cycles from T. done follows in the next cycle.
- Back-to-back operation: a new request can be accepted in the same cycle that done pulses.
- All outputs are registered.

## Configuration
- LATCH_WR_CTRL_READBACK_EN defined: adds input rd_q [DW] (data read back from the addressed latch) and output cmp_err.
  - On the last HOLD cycle, rd_q is compared with lat_d.
  - On a mismatch, cmp_err pulses together with done.
  - There is no compare for clears or for addr_err writes.
- Macro undefined: rd_q and cmp_err ports are absent; no compare logic.

## Test plan
- Reset, then write addr=2, data=0xA5 with default parameters -> lat_d=0xA5 from the accept edge. lat_en=4'b0100 for exactly 2 cycles, 1 cycle after accept. done pulses 4 cycles after accept.
- req_valid and clr_valid both high in IDLE -> clear is taken, lat_rstn low for 2 cycles, lat_en stays 0. The write is accepted after done.
- Write with addr=3 when NLATCH=3 -> lat_en never asserts. done and addr_err pulse together at the normal latency.
- Two back-to-back writes (addr 0 data 0x11, then addr 1 data 0x22) with valid held high -> the second write is accepted in the first write's done cycle. The enables never overlap.
- rstn driven low during OPEN of a write -> the next cycle has lat_en=0, lat_rstn=0, busy=0 and no done pulse.
- With READBACK_EN, write 0x3C and force rd_q=0x3D -> cmp_err=1 with done. With rd_q=0x3C -> cmp_err=0.

Source files
------------

// File: rtl/latch_wr_ctrl_if.sv
// Request-side handshake bundle for latch_wr_ctrl: write and clear-all requests
// share a single ready that the controller returns.
interface latch_wr_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          clr_valid;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output clr_valid,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  clr_valid,
        output req_ready
    );
endinterface

// File: rtl/latch_wr_ctrl.sv
// Write-side sequencer for a transparent latch bank: setup / open / hold phasing
// for writes, timed clear-all. Optional read-back compare: LATCH_WR_CTRL_READBACK_EN.
module latch_wr_ctrl #(
    parameter int unsigned DW        = 8,
    parameter int unsigned NLATCH    = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    latch_wr_ctrl_if.slave    bus,
    output logic [DW-1:0]     lat_d,
    output logic [NLATCH-1:0] lat_en,
    output logic              lat_rstn,
    output logic              busy,
    output logic              done,
    output logic              addr_err
`ifdef LATCH_WR_CTRL_READBACK_EN
    ,
    input  logic [DW-1:0]     rd_q,
    output logic              cmp_err
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] OPEN  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;

    localparam int unsigned MAX_SO = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int unsigned MAXC   = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
    localparam int unsigned CW     = $clog2(MAXC + 1);

    logic [2:0]        state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [AW-1:0]     addr_q, addr_n;
    logic              ready_q;
    logic [DW-1:0]     d_n;
    logic [NLATCH-1:0] en_n;
    logic              done_n;
    logic              aerr_n;
    logic              addr_ok;
`ifdef LATCH_WR_CTRL_READBACK_EN
    logic              cmp_n;
`endif

    assign bus.req_ready = ready_q;
    assign addr_ok       = (32'(addr_q) < NLATCH);

    // Next-state values feed every output register, so outputs line up with the
    // state they describe instead of lagging it by a cycle.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        addr_n  = addr_q;
        d_n     = lat_d;
        done_n  = 1'b0;
        aerr_n  = 1'b0;
`ifdef LATCH_WR_CTRL_READBACK_EN
        cmp_n   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ready_q) begin
                    if (bus.clr_valid) begin
                        state_n = CLEAR;
                        cnt_n   = CW'(OPEN_CYC - 1);
                    end else if (bus.req_valid) begin
                        state_n = SETUP;
                        cnt_n   = CW'(SETUP_CYC - 1);
                        addr_n  = bus.req_addr;
                        d_n     = bus.req_data;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_n = OPEN;
                    cnt_n   = CW'(OPEN_CYC - 1);
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_n = HOLD;
                    cnt_n   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    aerr_n  = !addr_ok;
`ifdef LATCH_WR_CTRL_READBACK_EN
                    cmp_n   = addr_ok && (rd_q != lat_d);
`endif
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Out-of-range addresses match no bit, so the enable stays low.
        en_n = '0;
        if (state_n == OPEN) begin
            for (int unsigned i = 0; i < NLATCH; i++) begin
                en_n[i] = (32'(addr_n) == i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            lat_d    <= '0;
            lat_en   <= '0;
            lat_rstn <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            addr_err <= 1'b0;
`ifdef LATCH_WR_CTRL_READBACK_EN
            cmp_err  <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            addr_q   <= addr_n;
            ready_q  <= (state_n == IDLE);
            lat_d    <= d_n;
            lat_en   <= en_n;
            lat_rstn <= (state_n != CLEAR);
            busy     <= (state_n != IDLE);
            done     <= done_n;
            addr_err <= aerr_n;
`ifdef LATCH_WR_CTRL_READBACK_EN
            cmp_err  <= cmp_n;
`endif
        end
    end

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Bench for latch_wr_ctrl: directed vector table, read-back corner cases when
// LATCH_WR_CTRL_READBACK_EN is defined, then random traffic against a timeline model.
module tb_latch_wr_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned S  = 1;
    localparam int unsigned O  = 2;
    localparam int unsigned H  = 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;

    logic [DW-1:0] d4, d3;
    logic [3:0]    en4;
    logic [2:0]    en3;
    logic          lr4, lr3, b4, b3, dn4, dn3, ae4, ae3, ce4, ce3;
`ifdef LATCH_WR_CTRL_READBACK_EN
    logic [DW-1:0] rdq = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    latch_wr_ctrl_if #(.DW(DW), .AW(AW)) bus4 ();
    latch_wr_ctrl_if #(.DW(DW), .AW(AW)) bus3 ();

    assign bus4.req_valid = valid;
    assign bus4.clr_valid = clr;
    assign bus4.req_addr  = addr;
    assign bus4.req_data  = data;
    assign bus3.req_valid = valid;
    assign bus3.clr_valid = clr;
    assign bus3.req_addr  = addr;
    assign bus3.req_data  = data;

    latch_wr_ctrl #(.DW(DW), .NLATCH(4), .AW(AW), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)) u_dut4 (
        .clk(clk), .rstn(rstn), .bus(bus4), .lat_d(d4), .lat_en(en4), .lat_rstn(lr4),
        .busy(b4), .done(dn4), .addr_err(ae4)
`ifdef LATCH_WR_CTRL_READBACK_EN
        , .rd_q(rdq), .cmp_err(ce4)
`endif
    );

    latch_wr_ctrl #(.DW(DW), .NLATCH(3), .AW(AW), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)) u_dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3), .lat_d(d3), .lat_en(en3), .lat_rstn(lr3),
        .busy(b3), .done(dn3), .addr_err(ae3)
`ifdef LATCH_WR_CTRL_READBACK_EN
        , .rd_q(rdq), .cmp_err(ce3)
`endif
    );

`ifndef LATCH_WR_CTRL_READBACK_EN
    assign ce4 = 1'b0;
    assign ce3 = 1'b0;
`endif

    typedef struct packed {
        logic          rdy, busy, done, aerr, lrst, cmp;
        logic [3:0]    en;
        logic [DW-1:0] d;
    } obs_t;

    typedef struct {
        logic rstn, valid, clr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic rdy, busy, done, lrst;
        logic [3:0] en4, en3;
        logic aerr3;
        logic [DW-1:0] d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic c, logic [AW-1:0] a, logic [DW-1:0] dt,
                                logic rdy, logic bsy, logic dn, logic lrst,
                                logic [3:0] e4, logic [3:0] e3, logic ae, logic [DW-1:0] d);
        vec_t x;
        x.rstn = r; x.valid = v; x.clr = c; x.addr = a; x.data = dt;
        x.rdy = rdy; x.busy = bsy; x.done = dn; x.lrst = lrst;
        x.en4 = e4; x.en3 = e3; x.aerr3 = ae; x.d = d;
        return x;
    endfunction

    function automatic obs_t get4();
        obs_t o;
        o.rdy = bus4.req_ready; o.busy = b4; o.done = dn4; o.aerr = ae4;
        o.lrst = lr4; o.cmp = ce4; o.en = en4; o.d = d4;
        return o;
    endfunction

    function automatic obs_t get3();
        obs_t o;
        o.rdy = bus3.req_ready; o.busy = b3; o.done = dn3; o.aerr = ae3;
        o.lrst = lr3; o.cmp = ce3; o.en = {1'b0, en3}; o.d = d3;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b aerr=%b lrst=%b cmp=%b en=%b d=%h, required rdy=%b busy=%b done=%b aerr=%b lrst=%b cmp=%b en=%b d=%h",
                     name, got.rdy, got.busy, got.done, got.aerr, got.lrst, got.cmp, got.en, got.d,
                     exp.rdy, exp.busy, exp.done, exp.aerr, exp.lrst, exp.cmp, exp.en, exp.d);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Timeline model: an operation is just its kind, start edge and elapsed cycles.
    bit              m_rst = 1'b1;
    int              m_op = 0;          // 0 none, 1 write, 2 clear
    int unsigned     m_el = 0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_d = '0;
    bit              m_done = 1'b0;
    int              m_done_op = 0;
    bit              m_mis = 1'b0;

    task automatic model_edge(input logic r, input logic v, input logic c,
                              input logic [AW-1:0] a, input logic [DW-1:0] dt, input logic mis);
        bit was_ready;
        if (!r) begin
            m_rst = 1'b1; m_op = 0; m_d = '0; m_done = 1'b0;
            return;
        end
        was_ready = !m_rst && (m_op == 0);
        m_rst  = 1'b0;
        m_done = 1'b0;
        if (m_op != 0) begin
            m_el++;
            if (m_el == ((m_op == 1) ? (S + O + H) : O)) begin
                m_done = 1'b1; m_done_op = m_op; m_op = 0;
            end
        end else if (was_ready && (c || v)) begin
            m_el = 0;
            if (c) begin
                m_op = 2;
            end else begin
                m_op = 1; m_addr = a; m_d = dt; m_mis = mis;
            end
        end
    endtask

    function automatic obs_t model_exp(input int unsigned nl);
        obs_t e;
        bit in_rng;
        in_rng = (32'(m_addr) < nl);
        e.rdy  = !m_rst && (m_op == 0);
        e.busy = (m_op != 0);
        e.done = m_done;
        e.lrst = !m_rst && (m_op != 2);
        e.aerr = m_done && (m_done_op == 1) && !in_rng;
        e.en   = (m_op == 1 && m_el >= S && m_el < S + O && in_rng) ? (4'b0001 << m_addr) : 4'b0000;
        e.d    = m_d;
`ifdef LATCH_WR_CTRL_READBACK_EN
        e.cmp  = m_done && (m_done_op == 1) && in_rng && m_mis;
`else
        e.cmp  = 1'b0;
`endif
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e4, e3;
        //          r v c a  data   | rdy bsy dn lr  en4      en3     ae3 d
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 4'b0000,4'b0000,0,8'h00));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 4'b0000,4'b0000,0,8'h00));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,0,1, 4'b0000,4'b0000,0,8'h00));
        tbl.push_back(mk(1,1,0,2,8'hA5, 0,1,0,1, 4'b0000,4'b0000,0,8'hA5));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0100,4'b0100,0,8'hA5));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0100,4'b0100,0,8'hA5));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0000,4'b0000,0,8'hA5));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,1,1, 4'b0000,4'b0000,0,8'hA5));
        tbl.push_back(mk(1,1,1,1,8'h5A, 0,1,0,0, 4'b0000,4'b0000,0,8'hA5));
        tbl.push_back(mk(1,1,1,1,8'h5A, 0,1,0,0, 4'b0000,4'b0000,0,8'hA5));
        tbl.push_back(mk(1,1,1,1,8'h5A, 1,0,1,1, 4'b0000,4'b0000,0,8'hA5));
        tbl.push_back(mk(1,1,0,1,8'h5A, 0,1,0,1, 4'b0000,4'b0000,0,8'h5A));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0010,4'b0010,0,8'h5A));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0010,4'b0010,0,8'h5A));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0000,4'b0000,0,8'h5A));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,1,1, 4'b0000,4'b0000,0,8'h5A));
        tbl.push_back(mk(1,1,0,3,8'h77, 0,1,0,1, 4'b0000,4'b0000,0,8'h77));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b1000,4'b0000,0,8'h77));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b1000,4'b0000,0,8'h77));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0000,4'b0000,0,8'h77));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,1,1, 4'b0000,4'b0000,1,8'h77));
        tbl.push_back(mk(1,1,0,0,8'h11, 0,1,0,1, 4'b0000,4'b0000,0,8'h11));
        tbl.push_back(mk(1,1,0,1,8'h22, 0,1,0,1, 4'b0001,4'b0001,0,8'h11));
        tbl.push_back(mk(1,1,0,1,8'h22, 0,1,0,1, 4'b0001,4'b0001,0,8'h11));
        tbl.push_back(mk(1,1,0,1,8'h22, 0,1,0,1, 4'b0000,4'b0000,0,8'h11));
        tbl.push_back(mk(1,1,0,1,8'h22, 1,0,1,1, 4'b0000,4'b0000,0,8'h11));
        tbl.push_back(mk(1,1,0,1,8'h22, 0,1,0,1, 4'b0000,4'b0000,0,8'h22));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0010,4'b0010,0,8'h22));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0010,4'b0010,0,8'h22));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0000,4'b0000,0,8'h22));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,1,1, 4'b0000,4'b0000,0,8'h22));
        tbl.push_back(mk(1,1,0,2,8'h33, 0,1,0,1, 4'b0000,4'b0000,0,8'h33));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,0,1, 4'b0100,4'b0100,0,8'h33));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0,0, 4'b0000,4'b0000,0,8'h00));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,0,1, 4'b0000,4'b0000,0,8'h00));
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,0,1, 4'b0000,4'b0000,0,8'h00));

        @(negedge clk);
        foreach (tbl[i]) begin
            rstn = tbl[i].rstn; valid = tbl[i].valid; clr = tbl[i].clr;
            addr = tbl[i].addr; data = tbl[i].data;
            tick();
            e4 = '{rdy: tbl[i].rdy, busy: tbl[i].busy, done: tbl[i].done, aerr: 1'b0,
                   lrst: tbl[i].lrst, cmp: 1'b0, en: tbl[i].en4, d: tbl[i].d};
            e3 = e4;
            e3.en = tbl[i].en3;
            e3.aerr = tbl[i].aerr3;
            check($sformatf("tbl4[%0d]", i), get4(), e4);
            check($sformatf("tbl3[%0d]", i), get3(), e3);
`ifdef LATCH_WR_CTRL_READBACK_EN
            rdq = tbl[i].d;
`endif
        end
        valid = 1'b0; clr = 1'b0;

`ifdef LATCH_WR_CTRL_READBACK_EN
        // Mismatching read-back, then matching, then out-of-range on the 3-latch bank.
        rdq = 8'h3D; valid = 1'b1; addr = 2'd0; data = 8'h3C;
        tick(); valid = 1'b0;
        repeat (4) tick();
        check_bit("rb_mis_done", dn4, 1'b1);
        check_bit("rb_mis_cmp", ce4, 1'b1);
        rdq = 8'h3C; valid = 1'b1;
        tick(); valid = 1'b0;
        repeat (4) tick();
        check_bit("rb_match_done", dn4, 1'b1);
        check_bit("rb_match_cmp", ce4, 1'b0);
        rdq = 8'h00; valid = 1'b1; addr = 2'd3; data = 8'hF0;
        tick(); valid = 1'b0;
        repeat (4) tick();
        check_bit("rb_aerr_flag", ae3, 1'b1);
        check_bit("rb_aerr_nocmp", ce3, 1'b0);
        check_bit("rb_inrange_cmp", ce4, 1'b1);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic mis;
            mis   = 1'b0;
            rstn  = (n == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            valid = $urandom_range(0, 1);
            clr   = ($urandom_range(0, 7) == 0);
            addr  = AW'($urandom_range(0, 3));
            data  = DW'($urandom);
`ifdef LATCH_WR_CTRL_READBACK_EN
            if (!m_rst && m_op == 0) begin
                mis = $urandom_range(0, 1);
                rdq = mis ? (data ^ (8'h01 << $urandom_range(0, 7))) : data;
            end
`endif
            model_edge(rstn, valid, clr, addr, data, mis);
            tick();
            check($sformatf("rnd4[%0d]", n), get4(), model_exp(4));
            check($sformatf("rnd3[%0d]", n), get3(), model_exp(3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
